// File: rtl/tiled_systolic_engine_pkg.sv
// Shared state encoding, default geometry and the beat-count helper for the tiled systolic engine.
package tse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } tse_state_e;

  localparam int TSE_IN_W      = 8;
  localparam int TSE_OUT_W     = 24;
  localparam int TSE_ROWS      = 3;
  localparam int TSE_COLS      = 3;
  localparam int TSE_K_TILE    = 3;
  localparam int TSE_MAX_TILES = 9;

  function automatic int tse_beats(input int tiles, input int k_tile);
    return tiles * k_tile;
  endfunction

endpackage

// File: rtl/tiled_systolic_engine_if.sv
// Job/k-slice/result bundle of the systolic engine; slave side is the engine, master side its driver.
// Handshakes are valid/ready: a beat or result moves only on a cycle where both are high.
interface tse_if
  import tse_pkg::*;
#(
  parameter int IN_W      = TSE_IN_W,
  parameter int OUT_W     = TSE_OUT_W,
  parameter int ROWS      = TSE_ROWS,
  parameter int COLS      = TSE_COLS,
  parameter int MAX_TILES = TSE_MAX_TILES
);
  localparam int NT_W  = $clog2(MAX_TILES + 1);
  localparam int IDX_W = $clog2(ROWS * COLS);

  logic                   start;
  logic [NT_W-1:0]        num_tiles;
  logic                   in_valid;
  logic                   in_ready;
  logic [IN_W*ROWS-1:0]   a_vec;
  logic [IN_W*COLS-1:0]   b_vec;
  logic                   res_valid;
  logic                   res_ready;
  logic [OUT_W-1:0]       res_data;
  logic [IDX_W-1:0]       res_idx;
  logic                   busy;
  logic                   done;

  modport slave (
    input  start, num_tiles, in_valid, a_vec, b_vec, res_ready,
    output in_ready, res_valid, res_data, res_idx, busy, done
  );

  modport master (
    output start, num_tiles, in_valid, a_vec, b_vec, res_ready,
    input  in_ready, res_valid, res_data, res_idx, busy, done
  );

endinterface

// File: rtl/tiled_systolic_engine_mac_pe.sv
// One systolic cell: acc += a*b each cycle, a forwarded right and b down through 1-cycle registers.
// No backpressure; i_clr synchronously zeroes the accumulator and both forwarding registers.
module mac_pe
  import tse_pkg::*;
#(
  parameter int IN_W  = TSE_IN_W,
  parameter int OUT_W = TSE_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  output logic [IN_W-1:0]  o_a,
  output logic [IN_W-1:0]  o_b,
  output logic [OUT_W-1:0] o_acc
);

  logic [IN_W-1:0]   r_a;
  logic [IN_W-1:0]   r_b;
  logic [OUT_W-1:0]  r_acc;
  logic [2*IN_W-1:0] w_prod;

  // Unsigned full-width product; the accumulator wraps at OUT_W bits.
  assign w_prod = {{IN_W{1'b0}}, i_a} * {{IN_W{1'b0}}, i_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= r_acc + OUT_W'(w_prod);
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/tiled_systolic_engine.sv
// Output-stationary ROWSxCOLS systolic matmul: LOAD k-slices, DRAIN ROWS+COLS-1 cycles, then stream results.
// in_ready only in LOAD (idle LOAD cycles inject zero bubbles); result index holds while res_ready is low.
module tiled_systolic_engine
  import tse_pkg::*;
#(
  parameter int IN_W      = TSE_IN_W,
  parameter int OUT_W     = TSE_OUT_W,
  parameter int ROWS      = TSE_ROWS,
  parameter int COLS      = TSE_COLS,
  parameter int K_TILE    = TSE_K_TILE,
  parameter int MAX_TILES = TSE_MAX_TILES
) (
  input  logic clk,
  input  logic reset,
  tse_if.slave bus
);

  localparam int IDX_W    = $clog2(ROWS * COLS);
  localparam int BC_W     = $clog2(MAX_TILES * K_TILE + 1);
  localparam int DR_W     = $clog2(ROWS + COLS);
  localparam int LAST_IDX = ROWS * COLS - 1;

  tse_state_e        r_state;
  tse_state_e        w_state_nxt;
  logic [BC_W-1:0]   r_beat;
  logic [BC_W-1:0]   r_total;
  logic [DR_W-1:0]   r_drain;
  logic [IDX_W-1:0]  r_idx;
  logic              r_done;

  logic              w_start_ok;
  logic              w_clr;
  logic              w_accept;
  logic              w_last_beat;
  logic              w_drain_end;
  logic              w_xfer;
  logic              w_last_xfer;
  logic              w_in_ready;
  logic              w_res_valid;
  logic              w_busy;

  logic [IN_W*ROWS-1:0] w_slice_a;
  logic [IN_W*COLS-1:0] w_slice_b;
  logic [IN_W-1:0]      w_a_edge [ROWS];
  logic [IN_W-1:0]      w_b_edge [COLS];
  logic [IN_W-1:0]      w_a_pe   [ROWS][COLS];
  logic [IN_W-1:0]      w_b_pe   [ROWS][COLS];
  logic [OUT_W-1:0]     w_acc    [ROWS][COLS];
  logic [OUT_W-1:0]     w_res_sel;

  assign w_start_ok  = (r_state == IDLE) && bus.start;
  assign w_clr       = w_start_ok;
  assign w_accept    = (r_state == LOAD) && bus.in_valid;
  assign w_last_beat = w_accept && (r_beat == r_total - BC_W'(1));
  assign w_drain_end = (r_state == DRAIN) && (r_drain == DR_W'(ROWS + COLS - 2));
  assign w_xfer      = (r_state == OUTPUT) && bus.res_ready;
  assign w_last_xfer = w_xfer && (r_idx == IDX_W'(LAST_IDX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_res_valid = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = (bus.num_tiles == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        w_in_ready = 1'b1;
        if (w_last_beat) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_end) begin
          w_state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        w_res_valid = 1'b1;
        if (w_last_xfer) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat  <= '0;
      r_total <= '0;
      r_drain <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_clr) begin
        r_beat  <= '0;
        r_total <= BC_W'(tse_beats(int'(bus.num_tiles), K_TILE));
      end else if (w_accept) begin
        r_beat <= r_beat + 1'b1;
      end
      r_drain <= (r_state == DRAIN) ? r_drain + 1'b1 : '0;
      if (w_last_xfer) begin
        r_idx <= '0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 1'b1;
      end
      r_done <= w_last_xfer;
    end
  end

  // Every LOAD/DRAIN cycle injects a slice; anything not accepted enters as zeros so it adds nothing.
  assign w_slice_a = w_accept ? bus.a_vec : '0;
  assign w_slice_b = w_accept ? bus.b_vec : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign w_a_edge[r] = w_slice_a[IN_W-1:0];
    end else begin : g_delay
      logic [IN_W-1:0] r_sh [r];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < r; i++) r_sh[i] <= '0;
        end else if (w_clr) begin
          for (int i = 0; i < r; i++) r_sh[i] <= '0;
        end else begin
          r_sh[0] <= w_slice_a[(r+1)*IN_W-1 -: IN_W];
          for (int i = 1; i < r; i++) r_sh[i] <= r_sh[i-1];
        end
      end
      assign w_a_edge[r] = r_sh[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    if (c == 0) begin : g_direct
      assign w_b_edge[c] = w_slice_b[IN_W-1:0];
    end else begin : g_delay
      logic [IN_W-1:0] r_sh [c];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < c; i++) r_sh[i] <= '0;
        end else if (w_clr) begin
          for (int i = 0; i < c; i++) r_sh[i] <= '0;
        end else begin
          r_sh[0] <= w_slice_b[(c+1)*IN_W-1 -: IN_W];
          for (int i = 1; i < c; i++) r_sh[i] <= r_sh[i-1];
        end
      end
      assign w_b_edge[c] = r_sh[c-1];
    end
  end

  // Skew of r (rows) plus c (forwarding hops) lines up A[r][k] and B[k][c] at PE(r,c).
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [IN_W-1:0] w_a_in;
      logic [IN_W-1:0] w_b_in;
      if (c == 0) begin : g_a_first
        assign w_a_in = w_a_edge[r];
      end else begin : g_a_chain
        assign w_a_in = w_a_pe[r][c-1];
      end
      if (r == 0) begin : g_b_first
        assign w_b_in = w_b_edge[c];
      end else begin : g_b_chain
        assign w_b_in = w_b_pe[r-1][c];
      end
      mac_pe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
      ) u_pe (
        .clk   (clk),
        .rst   (reset),
        .i_clr (w_clr),
        .i_a   (w_a_in),
        .i_b   (w_b_in),
        .o_a   (w_a_pe[r][c]),
        .o_b   (w_b_pe[r][c]),
        .o_acc (w_acc[r][c])
      );
    end
  end

  always_comb begin
    w_res_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_idx == IDX_W'(r * COLS + c)) begin
          w_res_sel = w_acc[r][c];
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.res_valid = w_res_valid;
  assign bus.res_data  = w_res_valid ? w_res_sel : '0;
  assign bus.res_idx   = r_idx;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_tiled_systolic_engine.sv
// Directed bench: two engines (24-bit and 16-bit results) share one stimulus stream.
module tb_tiled_systolic_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tse_if #(.OUT_W(24)) if0 ();
  tse_if #(.OUT_W(16)) if1 ();

  logic        t_start;
  logic [3:0]  t_nt;
  logic        t_valid;
  logic [23:0] t_a;
  logic [23:0] t_b;
  logic        t_rdy;

  assign if0.start     = t_start;
  assign if0.num_tiles = t_nt;
  assign if0.in_valid  = t_valid;
  assign if0.a_vec     = t_a;
  assign if0.b_vec     = t_b;
  assign if0.res_ready = t_rdy;
  assign if1.start     = t_start;
  assign if1.num_tiles = t_nt;
  assign if1.in_valid  = t_valid;
  assign if1.a_vec     = t_a;
  assign if1.b_vec     = t_b;
  assign if1.res_ready = t_rdy;

  tiled_systolic_engine #(
    .IN_W(8), .OUT_W(24), .ROWS(3), .COLS(3), .K_TILE(3), .MAX_TILES(9)
  ) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (if0)
  );

  tiled_systolic_engine #(
    .IN_W(8), .OUT_W(16), .ROWS(3), .COLS(3), .K_TILE(3), .MAX_TILES(9)
  ) u_dut16 (
    .clk   (clk),
    .reset (rst),
    .bus   (if1)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_v [9];
  logic [23:0] id_b [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag, input int cycles);
    n_asserts++;
    n_fail++;
    $error("FAIL %s: no event after %0d cycles, expected one", tag, cycles);
  endtask

  task automatic start_job(input logic [3:0] nt);
    t_nt    = nt;
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    check("busy_after_start", 32'(if0.busy), 32'd1);
  endtask

  task automatic send_beat(input logic [23:0] a, input logic [23:0] b);
    int n;
    n       = 0;
    t_a     = a;
    t_b     = b;
    t_valid = 1'b1;
    while (if0.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) timeout("in_ready", n);
    @(posedge clk); #1;
    t_valid = 1'b0;
  endtask

  task automatic collect(input int hold_at);
    int n;
    t_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (if0.res_valid !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 100) begin
        timeout("res_valid", n);
        t_rdy = 1'b0;
        return;
      end
      check($sformatf("res_idx[%0d]", i), 32'(if0.res_idx), 32'(i));
      check($sformatf("res_data[%0d]", i), 32'(if0.res_data), 32'(exp_v[i]));
      check($sformatf("res_data16[%0d]", i), 32'(if1.res_data), 32'(exp_v[i]) & 32'hFFFF);
      if (i == hold_at) begin
        t_rdy = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check("hold_valid", 32'(if0.res_valid), 32'd1);
          check("hold_idx", 32'(if0.res_idx), 32'(i));
          check("hold_data", 32'(if0.res_data), 32'(exp_v[i]));
        end
        t_rdy = 1'b1;
      end
      @(posedge clk); #1;
    end
    t_rdy = 1'b0;
    check("done_pulse", 32'(if0.done), 32'd1);
    check("idle_after_done", 32'(if0.busy), 32'd0);
  endtask

  task automatic identity_beats();
    for (int k = 0; k < 3; k++) send_beat(24'h1 << (8 * k), id_b[k]);
  endtask

  initial begin
    rst     = 1'b1;
    t_start = 1'b0;
    t_nt    = '0;
    t_valid = 1'b0;
    t_a     = '0;
    t_b     = '0;
    t_rdy   = 1'b0;
    id_b[0] = 24'h030201;
    id_b[1] = 24'h060504;
    id_b[2] = 24'h090807;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(if0.in_ready), 32'd0);
    check("rst_res_valid", 32'(if0.res_valid), 32'd0);
    check("rst_res_data", 32'(if0.res_data), 32'd0);
    check("rst_res_idx", 32'(if0.res_idx), 32'd0);
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_done", 32'(if0.done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity A times B = B, with drain latency and a 5-cycle stall at idx 4.
    start_job(4'd1);
    check("load_in_ready", 32'(if0.in_ready), 32'd1);
    identity_beats();
    check("drain_in_ready", 32'(if0.in_ready), 32'd0);
    check("drain_busy", 32'(if0.busy), 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
      check("drain_no_valid", 32'(if0.res_valid), 32'd0);
    end
    @(posedge clk); #1;
    check("valid_rise", 32'(if0.res_valid), 32'd1);
    for (int i = 0; i < 9; i++) exp_v[i] = i + 1;
    collect(4);

    // Start issued in the done cycle is taken; start held during LOAD is ignored.
    start_job(4'd9);
    check("restart_in_ready", 32'(if0.in_ready), 32'd1);
    check("done_one_cycle", 32'(if0.done), 32'd0);
    for (int k = 0; k < 27; k++) begin
      if (k == 5) t_start = 1'b1;
      if (k == 26) t_start = 1'b0;
      send_beat(24'h010101, 24'h010101);
    end
    for (int i = 0; i < 9; i++) exp_v[i] = 27;
    collect(-1);

    // Same job with a bubble cycle after every beat.
    start_job(4'd9);
    for (int k = 0; k < 27; k++) begin
      if (k == 26) check("ready_before_beat27", 32'(if0.in_ready), 32'd1);
      send_beat(24'h010101, 24'h010101);
      if (k < 26) begin
        @(posedge clk); #1;
      end
    end
    check("drain_after_beat27", 32'(if0.in_ready), 32'd0);
    collect(-1);

    // Maximum operands: 27*255*255 = 1755675, which wraps to 51739 in 16 bits.
    start_job(4'd9);
    for (int k = 0; k < 27; k++) send_beat(24'hFFFFFF, 24'hFFFFFF);
    for (int i = 0; i < 9; i++) exp_v[i] = 1755675;
    collect(-1);

    // Zero tiles skips LOAD and must still clear the previous results.
    start_job(4'd0);
    check("zero_tiles_no_load", 32'(if0.in_ready), 32'd0);
    for (int i = 0; i < 9; i++) exp_v[i] = 0;
    collect(-1);

    // Reset in the middle of LOAD, then a clean identity job.
    start_job(4'd9);
    for (int k = 0; k < 10; k++) send_beat(24'h010101, 24'h010101);
    rst = 1'b1;
    #1;
    check("midload_rst_busy", 32'(if0.busy), 32'd0);
    check("midload_rst_in_ready", 32'(if0.in_ready), 32'd0);
    check("midload_rst_res_valid", 32'(if0.res_valid), 32'd0);
    check("midload_rst_done", 32'(if0.done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_job(4'd1);
    identity_beats();
    for (int i = 0; i < 9; i++) exp_v[i] = i + 1;
    collect(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
